// File: rtl/control_semafor.sv
// control_semafor
// ----------------
// Central sequencer of the traffic-light intersection. Rotates green phases
// NORD -> VEST -> SUD -> EST with an all-red clearance between phases, and
// falls back to blinking yellow on a night request or a phase timeout.
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   rst            asynchronous reset, active-high
//   tick           one-clk-wide timebase enable pulse
//   noapte         night-mode request (level)
//   ready_N/V/S/E  phase-complete flags from the direction modules
//   stare_semafor  registered phase code: 000 all-red, 001 N, 010 V,
//                  011 S, 100 E, 111 blinking yellow
//   eroare         sticky timeout fault flag
//   schimbare      one-cycle pulse on every entry into a direction phase
module control_semafor #(
    parameter int CLEAR_TICKS   = 2,
    parameter int TIMEOUT_TICKS = 40,
    parameter int CNT_W         = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       noapte,
    input  logic       ready_N,
    input  logic       ready_V,
    input  logic       ready_S,
    input  logic       ready_E,
    output logic [2:0] stare_semafor,
    output logic       eroare,
    output logic       schimbare
);

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_PHASE  = 2'd1,
        ST_NOAPTE = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(CLEAR_TICKS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       ready_q, ready_d;
    logic [2:0]       stare_q, stare_d;
    logic             eroare_q, eroare_d;
    logic             schimbare_q, schimbare_d;

    logic [3:0]       ready_vec;
    logic [3:0]       ready_rise;
    logic             accept;

    // Ready flags packed in pointer order (0=N, 1=V, 2=S, 3=E). Only the
    // active direction's rising edge counts, so a flag held high across a
    // phase entry must drop and rise again before it is accepted.
    always_comb begin
        ready_vec  = {ready_E, ready_S, ready_V, ready_N};
        ready_rise = ready_vec & ~ready_q;
        accept     = ready_rise[ptr_q];
    end

    // Next-state logic. The outputs are derived from the next state so that
    // the phase code, fault flag and change pulse all appear on the same edge
    // that takes the decision.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ready_d = ready_vec;

        unique case (state_q)
            ST_CLEAR: begin
                if (tick) begin
                    if (cnt_q == CLEAR_LAST) begin
                        cnt_d   = '0;
                        state_d = noapte ? ST_NOAPTE : ST_PHASE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PHASE: begin
                // Accept has priority over a coincident terminal tick.
                if (accept) begin
                    ptr_d   = ptr_q + 2'd1;
                    cnt_d   = '0;
                    state_d = noapte ? ST_NOAPTE : ST_CLEAR;
                end else if (tick) begin
                    if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_FAULT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_NOAPTE: begin
                cnt_d = '0;
                if (!noapte) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        unique case (state_d)
            ST_CLEAR:  stare_d = 3'b000;
            ST_PHASE:  stare_d = {1'b0, ptr_d} + 3'd1;
            default:   stare_d = 3'b111;
        endcase
        eroare_d    = (state_d == ST_FAULT);
        schimbare_d = (state_q == ST_CLEAR) && (state_d == ST_PHASE);
    end

    // State and output registers; reset returns everything, including the
    // sticky fault flag, to the power-up values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            ptr_q       <= 2'd0;
            cnt_q       <= '0;
            ready_q     <= 4'b0000;
            stare_q     <= 3'b000;
            eroare_q    <= 1'b0;
            schimbare_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            stare_q     <= stare_d;
            eroare_q    <= eroare_d;
            schimbare_q <= schimbare_d;
        end
    end

    assign stare_semafor = stare_q;
    assign eroare        = eroare_q;
    assign schimbare     = schimbare_q;

endmodule
